// File: rtl/matrix_fetch_arbiter_if.sv
// Bundle between matrix_fetch_arbiter, its two compute engines and the dual-port matrix store.
// The slave modport is the arbiter's view; the master modport is the engines-plus-memory view.
interface matrix_fetch_arbiter_if #(
    parameter int N = 32,
    parameter int W = 8
);
    localparam int IW = $clog2(N);

    logic [1:0]      req_in;
    logic [2*IW-1:0] row_req_in;
    logic [2*IW-1:0] col_req_in;
    logic            mem_rd_en;
    logic [IW-1:0]   mem_row_addr;
    logic [IW-1:0]   mem_col_addr;
    logic [N*W-1:0]  mem_row_data;
    logic [N*W-1:0]  mem_col_data;
    logic [N*W-1:0]  matA_row;
    logic [N*W-1:0]  matB_col;
    logic [IW-1:0]   row_out;
    logic [IW-1:0]   col_out;
    logic [1:0]      val_rows;
    logic            busy;
    logic [1:0]      overrun;

    modport slave (
        input  req_in, row_req_in, col_req_in, mem_row_data, mem_col_data,
        output mem_rd_en, mem_row_addr, mem_col_addr, matA_row, matB_col,
               row_out, col_out, val_rows, busy, overrun
    );

    modport master (
        output req_in, row_req_in, col_req_in, mem_row_data, mem_col_data,
        input  mem_rd_en, mem_row_addr, mem_col_addr, matA_row, matB_col,
               row_out, col_out, val_rows, busy, overrun
    );
endinterface

// File: rtl/matrix_fetch_arbiter.sv
// Round-robin arbiter sharing one dual-port matrix store (A rows, B columns) between two engines.
// Optional macro FETCH_CACHE_EN: reuse the last fetched row/col without a memory access on a tag hit.
module matrix_fetch_arbiter #(
    parameter int N            = 32,
    parameter int W            = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    matrix_fetch_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_pending, r_inflight, r_overrun, r_val_rows;
    logic [IW-1:0]   r_slot_row [2];
    logic [IW-1:0]   r_slot_col [2];
    logic            r_last_grant, r_gnt;
    logic [3:0]      r_cnt;
    logic            r_rd_en;
    logic [IW-1:0]   r_mem_row_addr, r_mem_col_addr, r_row_out, r_col_out;
    logic [N*W-1:0]  r_matA_row, r_matB_col;

    logic            w_gnt_id, w_hit, w_grant, w_capture, w_hit_resp;

    // Both pending: alternate away from the last winner; otherwise take the lone requester.
    assign w_gnt_id = (&r_pending) ? ~r_last_grant : ~r_pending[0];

`ifdef FETCH_CACHE_EN
    logic          r_tag_vld;
    logic [IW-1:0] r_tag_row, r_tag_col;

    assign w_hit = r_tag_vld && (r_slot_row[w_gnt_id] == r_tag_row)
                             && (r_slot_col[w_gnt_id] == r_tag_col);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tag_vld <= 1'b0;
            r_tag_row <= '0;
            r_tag_col <= '0;
        end else if (w_capture) begin
            r_tag_vld <= 1'b1;
            r_tag_row <= r_slot_row[r_gnt];
            r_tag_col <= r_slot_col[r_gnt];
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_hit_resp  = 1'b0;
        case (r_state)
            ST_IDLE: if (|r_pending) begin
                w_grant     = 1'b1;
                w_state_nxt = w_hit ? ST_HIT : ST_WAIT;
            end
            ST_WAIT: if (r_cnt == 4'd0) begin
                w_capture   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_HIT: begin
                w_hit_resp  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending      <= '0;
            r_inflight     <= '0;
            r_overrun      <= '0;
            r_val_rows     <= '0;
            r_slot_row     <= '{default: '0};
            r_slot_col     <= '{default: '0};
            r_last_grant   <= 1'b1;
            r_gnt          <= 1'b0;
            r_cnt          <= '0;
            r_rd_en        <= 1'b0;
            r_mem_row_addr <= '0;
            r_mem_col_addr <= '0;
            r_row_out      <= '0;
            r_col_out      <= '0;
            r_matA_row     <= '0;
            r_matB_col     <= '0;
        end else begin
            r_rd_en    <= w_grant && !w_hit;
            r_val_rows <= '0;

            if (w_grant) begin
                r_pending[w_gnt_id]  <= 1'b0;
                r_inflight[w_gnt_id] <= 1'b1;
                r_last_grant         <= w_gnt_id;
                r_gnt                <= w_gnt_id;
                r_cnt                <= 4'(READ_LATENCY);
                r_mem_row_addr       <= r_slot_row[w_gnt_id];
                r_mem_col_addr       <= r_slot_col[w_gnt_id];
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture || w_hit_resp) begin
                r_val_rows[r_gnt] <= 1'b1;
                r_inflight[r_gnt] <= 1'b0;
                r_row_out         <= r_slot_row[r_gnt];
                r_col_out         <= r_slot_col[r_gnt];
            end
            if (w_capture) begin
                r_matA_row <= bus.mem_row_data;
                r_matB_col <= bus.mem_col_data;
            end

            // A slot is only rewritten once its previous request has been answered.
            for (int i = 0; i < 2; i++) begin
                if (bus.req_in[i]) begin
                    if (!r_pending[i] && !r_inflight[i]) begin
                        r_pending[i]  <= 1'b1;
                        r_slot_row[i] <= bus.row_req_in[i*IW +: IW];
                        r_slot_col[i] <= bus.col_req_in[i*IW +: IW];
                    end else begin
                        r_overrun[i]  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.mem_rd_en    = r_rd_en;
    assign bus.mem_row_addr = r_mem_row_addr;
    assign bus.mem_col_addr = r_mem_col_addr;
    assign bus.matA_row     = r_matA_row;
    assign bus.matB_col     = r_matB_col;
    assign bus.row_out      = r_row_out;
    assign bus.col_out      = r_col_out;
    assign bus.val_rows     = r_val_rows;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_matrix_fetch_arbiter.sv
// Directed bench for matrix_fetch_arbiter with a READ_LATENCY=2 pattern memory (A[r][k]=r*N+k, B[k][c]=k*N+c).
// The cache-hit vectors run only when FETCH_CACHE_EN is defined.
module tb_matrix_fetch_arbiter;
    localparam int N  = 32;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    matrix_fetch_arbiter_if #(.N(N), .W(W)) bus ();

    matrix_fetch_arbiter #(.N(N), .W(W), .READ_LATENCY(2)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [N*W-1:0] exp_a(input int r);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = 8'(r*N + k);
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_b(input int c);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = 8'(k*N + c);
        return v;
    endfunction

    // Two-stage memory: strobe sampled, then data registered; garbage outside the valid cycle.
    logic          s1_v = 1'b0;
    logic [IW-1:0] s1_r = '0, s1_c = '0;
    always @(posedge clk_in) begin
        s1_v <= bus.mem_rd_en;
        s1_r <= bus.mem_row_addr;
        s1_c <= bus.mem_col_addr;
        bus.mem_row_data <= s1_v ? exp_a(int'(s1_r)) : {N{8'hEE}};
        bus.mem_col_data <= s1_v ? exp_b(int'(s1_c)) : {N{8'hEE}};
    end

    task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive_req(input int i, input int r, input int c);
        bus.req_in[i]               = 1'b1;
        bus.row_req_in[i*IW +: IW]  = IW'(r);
        bus.col_req_in[i*IW +: IW]  = IW'(c);
    endtask

    task automatic clear_req();
        bus.req_in = '0;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        clear_req();
        repeat (2) step();
        rst_n_in = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd_n, nval, nresp, errs, got;
        int rd_k [2];
        int val_k [2];
        logic [1:0]    val_v [2];
        logic [IW-1:0] rd_row [2];
        logic [IW-1:0] vrow [2];

        bus.req_in       = '0;
        bus.row_req_in   = '0;
        bus.col_req_in   = '0;
        bus.mem_row_data = '0;
        bus.mem_col_data = '0;

        // Reset state and single-transaction latency.
        do_reset();
        check("rst_val", bus.val_rows, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ovr", bus.overrun, 2'b00);
        check("rst_rd", bus.mem_rd_en, 1'b0);
        check("rst_matA", bus.matA_row, '0);
        drive_req(0, 3, 7);
        step();
        clear_req();
        check("t1_rd_e0", bus.mem_rd_en, 1'b0);
        step();
        check("t1_rd_e1", bus.mem_rd_en, 1'b1);
        check("t1_raddr", bus.mem_row_addr, 5'd3);
        check("t1_caddr", bus.mem_col_addr, 5'd7);
        check("t1_busy", bus.busy, 1'b1);
        step();
        check("t1_rd_e2", bus.mem_rd_en, 1'b0);
        step();
        check("t1_val_e3", bus.val_rows, 2'b00);
        step();
        check("t1_val_e4", bus.val_rows, 2'b01);
        check("t1_matA", bus.matA_row, exp_a(3));
        check("t1_matB", bus.matB_col, exp_b(7));
        check("t1_row", bus.row_out, 5'd3);
        check("t1_col", bus.col_out, 5'd7);
        step();
        check("t1_val_e5", bus.val_rows, 2'b00);
        check("t1_idle", bus.busy, 1'b0);
        check("t1_hold", bus.matA_row, exp_a(3));

        // Simultaneous requests: requester 0 first, then 1.
        do_reset();
        drive_req(0, 1, 1);
        drive_req(1, 2, 2);
        step();
        clear_req();
        rd_n = 0; nval = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.mem_rd_en) begin
                if (rd_n < 2) begin rd_k[rd_n] = k; rd_row[rd_n] = bus.mem_row_addr; end
                rd_n++;
            end
            if (bus.val_rows != 2'b00) begin
                if (nval < 2) begin
                    val_k[nval] = k;
                    val_v[nval] = bus.val_rows;
                    check("t2_matA", bus.matA_row, exp_a(nval + 1));
                    check("t2_matB", bus.matB_col, exp_b(nval + 1));
                end
                nval++;
            end
        end
        check("t2_rd_n", rd_n, 2);
        check("t2_rd_k0", rd_k[0], 1);
        check("t2_rd_k1", rd_k[1], 5);
        check("t2_rd_row0", rd_row[0], 5'd1);
        check("t2_rd_row1", rd_row[1], 5'd2);
        check("t2_nval", nval, 2);
        check("t2_val_k0", val_k[0], 4);
        check("t2_val_k1", val_k[1], 8);
        check("t2_val_v0", val_v[0], 2'b01);
        check("t2_val_v1", val_v[1], 2'b10);

        // Overrun while pending/inflight; a pulse during the response cycle is accepted.
        drive_req(0, 4, 5);
        step();
        nval = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1 || k == 2) drive_req(0, 20, 21);
            else if (k == 5)      drive_req(0, 6, 9);
            else                  clear_req();
            step();
            if (k == 1) check("t3_ovr_set", bus.overrun, 2'b01);
            if (bus.val_rows != 2'b00) begin
                if (nval < 2) begin val_k[nval] = k; val_v[nval] = bus.val_rows; vrow[nval] = bus.row_out; end
                if (nval == 1) check("t3_col2", bus.col_out, 5'd9);
                nval++;
            end
        end
        clear_req();
        check("t3_nval", nval, 2);
        check("t3_val_k0", val_k[0], 4);
        check("t3_row0", vrow[0], 5'd4);
        check("t3_val_k1", val_k[1], 9);
        check("t3_row1", vrow[1], 5'd6);
        check("t3_val_v1", val_v[1], 2'b01);
        check("t3_ovr_sticky", bus.overrun, 2'b01);

        // Dummy engine sweeping all 1024 row/col pairs, re-requesting on each response.
        do_reset();
        nresp = 0; errs = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                drive_req(0, r, c);
                step();
                clear_req();
                got = 0;
                for (int t = 0; t < 12 && got == 0; t++) begin
                    step();
                    if (bus.val_rows[0]) got = 1;
                end
                if (got == 1) begin
                    nresp++;
                    if (bus.matA_row !== exp_a(r) || bus.matB_col !== exp_b(c) ||
                        bus.row_out !== IW'(r) || bus.col_out !== IW'(c)) errs++;
                end
            end
        end
        check("t4_nresp", nresp, 1024);
        check("t4_errs", errs, 0);
        check("t4_ovr", bus.overrun, 2'b00);

        // Reset during WAIT aborts the transaction.
        drive_req(1, 10, 11);
        step();
        clear_req();
        step();
        step();
        check("t5_in_wait", bus.busy, 1'b1);
        rst_n_in = 1'b0;
        #1;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_matA", bus.matA_row, '0);
        check("t5_row", bus.row_out, 5'd0);
        check("t5_raddr", bus.mem_row_addr, 5'd0);
        step();
        step();
        rst_n_in = 1'b1;
        nval = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.val_rows != 2'b00) nval++;
        end
        check("t5_no_val", nval, 0);
        drive_req(0, 12, 13);
        step();
        clear_req();
        repeat (4) step();
        check("t5_val", bus.val_rows, 2'b01);
        check("t5_matA2", bus.matA_row, exp_a(12));
        check("t5_matB2", bus.matB_col, exp_b(13));

`ifdef FETCH_CACHE_EN
        // Tag hit: response one cycle after grant, no memory strobe.
        drive_req(0, 12, 13);
        step();
        clear_req();
        step();
        check("t6_hit_rd", bus.mem_rd_en, 1'b0);
        step();
        check("t6_hit_val", bus.val_rows, 2'b01);
        check("t6_hit_matA", bus.matA_row, exp_a(12));
        check("t6_hit_row", bus.row_out, 5'd12);
        step();
        check("t6_hit_done", bus.val_rows, 2'b00);
        // Differing column misses and goes to memory.
        drive_req(0, 12, 14);
        step();
        clear_req();
        step();
        check("t6_miss_rd", bus.mem_rd_en, 1'b1);
        check("t6_miss_caddr", bus.mem_col_addr, 5'd14);
        repeat (3) step();
        check("t6_miss_val", bus.val_rows, 2'b01);
        check("t6_miss_matB", bus.matB_col, exp_b(14));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
